rom_byte_streamer: RTL
======================

# rom_byte_streamer

Initiator-side reader for the team's single-port, 8-bit, one-cycle-latency byte ROM. On a start command it fetches `length_i` consecutive bytes beginning at `base_addr_i`, wrapping modulo `ROM_DEPTH`, and presents them on a valid/ready byte stream with a last-beat marker. Downstream backpressure is absorbed without dropping or duplicating bytes. It feeds test-vector bytes, such as read sequences, into the pair-HMM datapath in simulation and on-chip.

## Interface
- `ROM_DEPTH`, default 2048: ROM depth in bytes; must be a power of two and at least 2.
- `AW`, default `$clog2(ROM_DEPTH)`: address width (localparam).
- `clock_i`  in  1: sole clock, rising edge.
- `reset_n_i`  in  1: reset, asynchronous, active-low.
- `start_i`  in  1: command strobe; sampled only in IDLE.
- `base_addr_i`  in  AW: first ROM address; sampled with `start_i`.
- `length_i`  in  AW+1: byte count, 0..ROM_DEPTH; sampled with `start_i`.
- `busy_o`  out  1: high from the cycle after an accepted start until the cycle `done_o` pulses.
- `done_o`  out  1: one-cycle pulse when the transfer completes.
- `rom_addr_o`  out  AW: ROM read address.
- `rom_read_en_o`  out  1: ROM read enable; data returns on `rom_data_i` one cycle later.
- `rom_data_i`  in  8: ROM read data.
- `m_data_o`  out  8: stream byte.
- `m_valid_o`  out  1: stream valid.
- `m_last_o`  out  1: marks the final byte of the transfer; qualified by `m_valid_o`.
- `m_ready_i`  in  1: downstream ready.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- **IDLE**
  - When `start_i` is high, latch base and length into the address counter and the remaining-issue counter `iss_left`; set the remaining-beat counter `beat_left` to the length.
  - If length is 0, go to DRAIN with nothing pending; `done_o` pulses the next cycle and no beat is emitted.
  - Otherwise go to FETCH.
- **FETCH**
  - Issue a read (`rom_read_en_o` = 1, `rom_addr_o` = current address) when `iss_left` > 0 and `occ + inflight − pop < 2`.
    - `occ`: bytes held in the 2-entry output FIFO.
    - `inflight`: a read was issued in the previous cycle.
    - `pop`: `m_valid_o & m_ready_i`.
  - Each issued read advances the address by +1 modulo ROM_DEPTH, so ROM_DEPTH−1 wraps to 0, and decrements `iss_left`.
  - When `iss_left` reaches 0, go to DRAIN.
- **DRAIN**
  - Issue no further reads. Each pop decrements `beat_left`.
  - When the pop with `beat_left` = 1 occurs, `done_o` pulses in the following cycle and the FSM returns to IDLE in that same cycle.
- Output FIFO: ROM data is written into the FIFO in the cycle after issue. `m_data_o` and `m_valid_o` come from the FIFO head.
- `m_last_o` = `m_valid_o` and (`beat_left` = 1).
- Stream rules:
  - Once `m_valid_o` is high it stays high, with `m_data_o` and `m_last_o` stable, until accepted.
  - `m_valid_o` never depends combinationally on `m_ready_i`.
- `start_i` outside IDLE is ignored. `rom_read_en_o` is never high outside FETCH.
- Reset values: FSM IDLE, FIFO empty. `busy_o`, `done_o`, `m_valid_o`, `m_last_o`, `rom_read_en_o` are all 0. `rom_addr_o` and `m_data_o` are 0.
- Reset asserted mid-transfer clears all state immediately. No `done_o` pulse is produced, and the in-flight ROM word is discarded.

## Timing
- Start sampled at edge 0: first `rom_read_en_o` is high in cycle 1, and the first byte is valid at `m_valid_o` in cycle 3.
- With `m_ready_i` held high: one byte per cycle. For length N, the last beat is accepted in cycle N+2 and `done_o` pulses in cycle N+3.
- Under stall: at most 2 bytes are buffered and at most 1 read is in flight. No overflow, no skipped address.
- `done_o` and the return to IDLE coincide. A new `start_i` is accepted from the cycle after `done_o`.

## Structure
- Package `rom_streamer_pkg`:
  - `state_t` enum {IDLE, FETCH, DRAIN}.
  - Localparam `FIFO_DEPTH` = 2.
- Sub-module `byte_fifo2`: 2-entry, 8-bit FIFO with registered outputs, push/pop, `occ` output, and the same clock and reset.
- Top level: the FSM, counters, and issue-credit logic.

## Test plan
- **Basic:** ROM[i] = i & 0xFF. Start base = 0x010, length = 4, ready high → bytes 0x10, 0x11, 0x12, 0x13 in cycles 3–6, `m_last_o` only with 0x13, `done_o` in cycle 7.
- **Wrap:** base = 2046, length = 4, ROM_DEPTH = 2048 → addresses 2046, 2047, 0, 1; data 0xFE, 0xFF, 0x00, 0x01.
- **Backpressure:** length = 8, `m_ready_i` toggling 1,0,0,1,… → all 8 bytes in order, no duplicates, and never more than 2 reads issued ahead of pops.
- **Zero length:** start with length = 0 → no `rom_read_en_o`, no `m_valid_o`, `done_o` pulses once, one cycle after start.
- **Start ignored while busy:** second `start_i` during FETCH with a different base → no effect, original sequence completes.
- **Reset mid-transfer:** assert `reset_n_i` low after 3 beats of 10 → all outputs 0 immediately. A later start with base = 0x100, length = 2 streams 0x00, 0x01 correctly.

Source files
------------

// File: rtl/rom_streamer_pkg.sv
// Shared types and constants for the ROM byte streamer.
package rom_streamer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Output buffer depth; the issue-credit check is sized against it.
   localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/byte_fifo2.sv
// Two-entry byte FIFO. Head data comes straight from storage registers,
// so the stream side never sees a combinational path from pop or push.
module byte_fifo2
   import rom_streamer_pkg::*;
(
   input  logic       clock_i,
   input  logic       reset_n_i,
   input  logic       push_i,
   input  logic [7:0] data_i,
   input  logic       pop_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic [1:0] occ_o
);

   logic [FIFO_DEPTH-1:0][7:0] mem_q;
   logic                       wr_q;
   logic                       rd_q;
   logic [1:0]                 occ_q;

   // Storage, pointers and occupancy; the caller guarantees no push into a full FIFO without a pop.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mem_q <= '0;
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         occ_q <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= ~wr_q;
         end
         if (pop_i) rd_q <= ~rd_q;
         case ({push_i, pop_i})
            2'b10:   occ_q <= occ_q + 2'd1;
            2'b01:   occ_q <= occ_q - 2'd1;
            default: ;
         endcase
      end
   end

   assign data_o  = mem_q[rd_q];
   assign valid_o = (occ_q != 2'd0);
   assign occ_o   = occ_q;

endmodule

// File: rtl/rom_byte_streamer.sv
// Reads a run of bytes from a one-cycle-latency ROM and streams them out
// on valid/ready with a last marker. Reads are only issued when the output
// FIFO is guaranteed room for the returning byte.
module rom_byte_streamer
   import rom_streamer_pkg::*;
#(
   parameter  int ROM_DEPTH = 2048,
   localparam int AW        = $clog2(ROM_DEPTH)
) (
   input  logic          clock_i,
   input  logic          reset_n_i,
   input  logic          start_i,
   input  logic [AW-1:0] base_addr_i,
   input  logic [AW:0]   length_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [AW-1:0] rom_addr_o,
   output logic          rom_read_en_o,
   input  logic [7:0]    rom_data_i,
   output logic [7:0]    m_data_o,
   output logic          m_valid_o,
   output logic          m_last_o,
   input  logic          m_ready_i
);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   iss_left_q, iss_left_d;
   logic [AW:0]   beat_left_q, beat_left_d;
   logic          inflight_q;
   logic          done_q, done_d;

   logic          issue;
   logic          pop;
   logic          credit;
   logic          fifo_valid;
   logic [1:0]    occ;

   assign pop = fifo_valid & m_ready_i;

   // Bytes already owed to the FIFO (held + in flight) minus the one leaving now must leave a free slot.
   assign credit = (int'(occ) + int'(inflight_q)) < (FIFO_DEPTH + int'(pop));

   // Next-state, counters and read issue.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      iss_left_d  = iss_left_q;
      beat_left_d = beat_left_q;
      done_d      = 1'b0;
      issue       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               addr_d      = base_addr_i;
               iss_left_d  = length_i;
               beat_left_d = length_i;
               if (length_i == '0) begin
                  // Empty transfer: report completion right away, DRAIN just unwinds.
                  state_d = DRAIN;
                  done_d  = 1'b1;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         FETCH: begin
            if (iss_left_q != '0 && credit) begin
               issue      = 1'b1;
               addr_d     = addr_q + AW'(1);
               iss_left_d = iss_left_q - (AW+1)'(1);
               if (iss_left_q == (AW+1)'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (beat_left_q == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Beats can leave during FETCH as well as DRAIN.
      if (pop) begin
         beat_left_d = beat_left_q - (AW+1)'(1);
         if (beat_left_q == (AW+1)'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
      end
   end

   // State registers; reset drops any in-flight ROM word.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         iss_left_q  <= '0;
         beat_left_q <= '0;
         inflight_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         iss_left_q  <= iss_left_d;
         beat_left_q <= beat_left_d;
         inflight_q  <= issue;
         done_q      <= done_d;
      end
   end

   byte_fifo2 u_fifo (
      .clock_i   (clock_i),
      .reset_n_i (reset_n_i),
      .push_i    (inflight_q),
      .data_i    (rom_data_i),
      .pop_i     (pop),
      .data_o    (m_data_o),
      .valid_o   (fifo_valid),
      .occ_o     (occ)
   );

   assign m_valid_o     = fifo_valid;
   assign m_last_o      = fifo_valid && (beat_left_q == (AW+1)'(1));
   assign rom_addr_o    = addr_q;
   assign rom_read_en_o = issue;
   assign done_o        = done_q;
   assign busy_o        = (state_q != IDLE) && !done_q;

endmodule
